// File: rtl/operand_pkg.sv
// Shared constants for the operand-select stage: source indices, default widths,
// and the occupancy encoding of its 2-entry result buffer.
package operand_pkg;
  localparam int SRC_REG  = 0;
  localparam int SRC_IMM  = 1;
  localparam int SRC_FWD0 = 2;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_IMM_W  = 12;

  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_FULL  = 2'd2
  } fifo_lvl_e;

  // A select port is never narrower than one bit, even for one or two sources.
  function automatic int sel_width(input int num_src);
    return (num_src > 2) ? $clog2(num_src) : 1;
  endfunction
endpackage

// File: rtl/opsel_fifo2.sv
// Two-entry result buffer. The occupancy state is the level output, so the
// FSM state is always visible to checkers.
module opsel_fifo2
  import operand_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        level,
  output logic [DATA_W-1:0] rdata
);
  fifo_lvl_e         state;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [DATA_W-1:0] mem [2];

  assign do_push = push && (state != LVL_FULL);
  assign do_pop  = pop && (state != LVL_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LVL_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case (state)
        LVL_EMPTY: if (do_push) state <= LVL_ONE;
        LVL_ONE: begin
          if (do_push && !do_pop)      state <= LVL_FULL;
          else if (!do_push && do_pop) state <= LVL_EMPTY;
        end
        LVL_FULL:  if (do_pop) state <= LVL_ONE;
        default:   state <= LVL_EMPTY;
      endcase
    end
  end

  // Storage is deliberately not reset; the empty state masks it on the read side.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign level = state;
  assign rdata = (state == LVL_EMPTY) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/operand_select_stage.sv
// Operand select stage: picks register / extended immediate / forwarded value,
// flags out-of-range selects, and buffers results with one cycle of latency.
module operand_select_stage
  import operand_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMM_W   = DEF_IMM_W,
  parameter int NUM_SRC = 4,
  localparam int SEL_W  = sel_width(NUM_SRC),
  localparam int FWD_N  = (NUM_SRC > 2) ? NUM_SRC - 2 : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]       register,
  input  logic [IMM_W-1:0]        immediate,
  input  logic                    imm_sext,
  input  logic [FWD_N*DATA_W-1:0] fwd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       result,
  output logic                    err,
  input  logic                    err_clr,
  output logic [1:0]              level
);
  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload until then, and ready never depends on valid.
  logic              push;
  logic              pop;
  logic              sel_bad;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] operand;
  int                sel_i;

  assign in_ready  = (level != LVL_FULL);
  assign out_valid = (level != LVL_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign sel_i     = int'(sel);

  if (IMM_W >= DATA_W) begin : g_imm_full
    assign imm_ext = immediate[DATA_W-1:0];
  end else begin : g_imm_ext
    assign imm_ext = {{(DATA_W-IMM_W){imm_sext & immediate[IMM_W-1]}}, immediate};
  end

  always_comb begin
    operand = '0;
    sel_bad = 1'b0;
    if (sel_i == SRC_REG) begin
      operand = register;
    end else if (sel_i == SRC_IMM) begin
      operand = imm_ext;
    end else if (sel_i >= NUM_SRC) begin
      sel_bad = 1'b1;
    end else begin
      for (int k = SRC_FWD0; k < NUM_SRC; k++) begin
        if (sel_i == k) operand = fwd[(k-SRC_FWD0)*DATA_W +: DATA_W];
      end
    end
  end

  // A new error on an accepted push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (push && sel_bad)  err <= 1'b1;
    else if (err_clr)          err <= 1'b0;
  end

  opsel_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (operand),
    .level (level),
    .rdata (result)
  );
endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage (NUM_SRC=3 so select index 3 is out of range);
// a queue-based reference model predicts every output after each clock edge.
module tb_operand_select_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [63:0] register_d;
  logic [11:0] immediate;
  logic        imm_sext;
  logic [63:0] fwd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        err;
  logic        err_clr;
  logic [1:0]  level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] exp_q[$];
  bit          m_err;

  always #5 clk = ~clk;

  operand_select_stage #(.DATA_W(64), .IMM_W(12), .NUM_SRC(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .register(register_d), .immediate(immediate), .imm_sext(imm_sext),
    .fwd(fwd), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .err(err), .err_clr(err_clr), .level(level)
  );

  // Expected operand; bit 64 marks an out-of-range select.
  function automatic logic [64:0] ref_op(int s, logic [63:0] r, logic [11:0] im,
                                         bit sx, logic [63:0] f0);
    logic [63:0] e;
    case (s)
      0: return {1'b0, r};
      1: begin
        e = {52'd0, im};
        if (sx && im >= 12'd2048) e = e - 64'd4096;
        return {1'b0, e};
      end
      2: return {1'b0, f0};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  function automatic logic [63:0] exp_result();
    return (exp_q.size() > 0) ? exp_q[0] : 64'd0;
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    bit push, pop;
    logic [64:0] v;
    push = in_valid && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && out_ready;
    v    = ref_op(int'(sel), register_d, immediate, imm_sext, fwd);
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(v[63:0]);
    if (push && v[64]) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = 2'd0;
    imm_sext = 1'b0; immediate = '0; register_d = '0; fwd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (level !== 2'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
    total_cnt++; if (result !== 64'd0) $display("FAIL reset_result got=%h exp=0", result); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_imm_ext();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1; immediate = 12'h800; imm_sext = 1'b1;
    tick();
    total_cnt++; if (result !== 64'hFFFF_FFFF_FFFF_F800) $display("FAIL imm_sext got=%h exp=%h", result, 64'hFFFF_FFFF_FFFF_F800); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL imm_sext_valid got=%b exp=1", out_valid); else pass_cnt++;
    imm_sext = 1'b0;
    tick();
    total_cnt++; if (result !== 64'h0000_0000_0000_0800) $display("FAIL imm_zext got=%h exp=%h", result, 64'h800); else pass_cnt++;
    immediate = 12'h7FF; imm_sext = 1'b1;
    tick();
    total_cnt++; if (result !== 64'h7FF) $display("FAIL imm_sext_pos got=%h exp=7ff", result); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL imm_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0; register_d = 64'h1234; fwd = 64'hBEEF;
    tick();
    total_cnt++; if (result !== 64'h1234) $display("FAIL b2b_first got=%h exp=1234", result); else pass_cnt++;
    total_cnt++; if (level !== 2'd1) $display("FAIL b2b_level1 got=%0d exp=1", level); else pass_cnt++;
    sel = 2'd2;
    tick();
    total_cnt++; if (result !== 64'hBEEF) $display("FAIL b2b_second got=%h exp=beef", result); else pass_cnt++;
    total_cnt++; if (level !== 2'd1) $display("FAIL b2b_level2 got=%0d exp=1", level); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++; if (level !== 2'd0) $display("FAIL b2b_drain got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [63:0] v1, v2, v3;
    v1 = {$urandom, $urandom}; v2 = {$urandom, $urandom}; v3 = {$urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; register_d = v1;
    tick();
    register_d = v2;
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    total_cnt++; if (level !== 2'd2) $display("FAIL bp_level got=%0d exp=2", level); else pass_cnt++;
    register_d = v3;
    tick();
    total_cnt++; if (level !== 2'd2) $display("FAIL bp_held_level got=%0d exp=2", level); else pass_cnt++;
    total_cnt++; if (result !== v1) $display("FAIL bp_stable got=%h exp=%h", result, v1); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (result !== v2) $display("FAIL bp_drain2 got=%h exp=%h", result, v2); else pass_cnt++;
    tick();
    total_cnt++; if (result !== v3) $display("FAIL bp_drain3 got=%h exp=%h", result, v3); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_error();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd3; register_d = 64'hDEAD;
    tick();
    total_cnt++; if (result !== 64'd0) $display("FAIL err_result got=%h exp=0", result); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL err_valid got=%b exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL err_set got=%b exp=1", err); else pass_cnt++;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (err !== 1'b1) $display("FAIL err_sticky cycle=%0d got=%b exp=1", i, err); else pass_cnt++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total_cnt++; if (err !== 1'b0) $display("FAIL err_clear got=%b exp=0", err); else pass_cnt++;
    tick();
    err_clr = 1'b1; in_valid = 1'b1; sel = 2'd3;
    tick();
    err_clr = 1'b0; in_valid = 1'b0;
    total_cnt++; if (err !== 1'b1) $display("FAIL err_set_wins got=%b exp=1", err); else pass_cnt++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; register_d = 64'h55;
    tick();
    tick();
    total_cnt++; if (level !== 2'd2) $display("FAIL rst_mid_pre got=%0d exp=2", level); else pass_cnt++;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_err = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (level !== 2'd0) $display("FAIL rst_mid_level got=%0d exp=0", level); else pass_cnt++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (out_valid !== 1'b0 || result !== 64'd0)
        $display("FAIL rst_mid_stale cycle=%0d valid=%b result=%h exp valid=0 result=0", i, out_valid, result);
      else pass_cnt++;
    end
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2; fwd = 64'hA1;
    tick();
    total_cnt++; if (level !== 2'd1) $display("FAIL pp_pre got=%0d exp=1", level); else pass_cnt++;
    out_ready = 1'b1; fwd = 64'hB2;
    tick();
    total_cnt++; if (level !== 2'd1) $display("FAIL pp_level got=%0d exp=1", level); else pass_cnt++;
    total_cnt++; if (result !== 64'hB2) $display("FAIL pp_result got=%h exp=b2", result); else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      err_clr    = ($urandom_range(0, 9) == 0);
      sel        = 2'($urandom_range(0, 3));
      register_d = {$urandom, $urandom};
      immediate  = 12'($urandom);
      imm_sext   = 1'($urandom);
      fwd        = {$urandom, $urandom};
      tick();
      total_cnt++;
      if (level !== 2'(exp_q.size()) || out_valid !== (exp_q.size() > 0) ||
          in_ready !== (exp_q.size() < 2) || result !== exp_result() || err !== m_err)
        $display("FAIL random cycle=%0d level=%0d/%0d valid=%b ready=%b result=%h/%h err=%b/%b",
                 i, level, exp_q.size(), out_valid, in_ready, result, exp_result(), err, m_err);
      else pass_cnt++;
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    m_err = 1'b0;
    test_reset();
    test_imm_ext();
    test_back_to_back();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_push_pop_one();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/operand_select_stage.md
OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

Interface
REQ-001 Parameter DATA_W, default 64, operand width in bits.
REQ-002 Parameter IMM_W, default 12, raw immediate width in bits; the block SHALL accept 1 <= IMM_W <= DATA_W.
REQ-003 Parameter NUM_SRC, default 4, number of operand sources; SEL_W = max(1, clog2(NUM_SRC)).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request this cycle.
REQ-008 sel  in  SEL_W  source index: 0 register, 1 immediate, 2..NUM_SRC-1 forwarded values.
REQ-009 register  in  DATA_W  register-file operand (source 0).
REQ-010 immediate  in  IMM_W  raw immediate (source 1).
REQ-011 imm_sext  in  1  1 = sign-extend the immediate, 0 = zero-extend it.
REQ-012 fwd  in  (NUM_SRC-2)*DATA_W  packed forwarded operands; source k is slice k-2.
REQ-013 out_valid  out  1  result present.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 result  out  DATA_W  selected operand.
REQ-016 err  out  1  sticky out-of-range-select flag.
REQ-017 err_clr  in  1  clears err.
REQ-018 level  out  2  number of buffered results (0..2).

Function
REQ-019 A request SHALL be accepted (push) when in_valid && in_ready, and a result SHALL be consumed (pop) when out_valid && out_ready.
REQ-020 On push, the block SHALL compute the operand combinationally from the sampled inputs and write it into a 2-entry FIFO; inputs are not needed after the accepting edge.
REQ-021 Latency SHALL be exactly 1 cycle: a push at edge N makes the result visible with out_valid=1 after edge N when the FIFO was empty; there is no combinational in-to-out path.
REQ-022 Immediate extension SHALL replicate immediate[IMM_W-1] into bits DATA_W-1..IMM_W when imm_sext=1, and zeros when imm_sext=0; when IMM_W equals DATA_W, the immediate SHALL pass through unchanged.
REQ-023 If sel >= NUM_SRC, the stored result SHALL be 0 and err SHALL be set on that push edge.
REQ-024 err SHALL remain set until a cycle with err_clr=1; if err_clr and a new error occur in the same cycle, err SHALL end set (set wins).
REQ-025 in_ready SHALL be a registered function of the state: 1 iff level < 2.
REQ-026 out_valid SHALL be 1 iff level > 0, and result SHALL present the oldest entry.
REQ-027 FIFO states SHALL be EMPTY (0), ONE (1), FULL (2): push only -> +1; pop only -> -1; push and pop together -> unchanged, with ordering preserved.
REQ-028 A push and pop in the same cycle while in ONE SHALL pop the old entry and store the new one, leaving level=1.
REQ-029 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-030 While out_valid=1 and out_ready=0, result SHALL hold stable.

Reset
REQ-031 On rst_n low, level, pointers and err SHALL clear immediately, out_valid=0 and in_ready=1, regardless of the clock.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries; no result SHALL appear after deassertion without a new push.
REQ-033 FIFO data storage is not required to reset; result SHALL read 0 whenever level=0.

Structure
REQ-034 The shared package operand_pkg SHALL hold the source-index constants (SRC_REG=0, SRC_IMM=1, SRC_FWD0=2) and the default DATA_W and IMM_W.
REQ-035 The 2-entry buffer SHALL be a sub-module, opsel_fifo2 (parameter DATA_W), carrying push/pop/level/data; the selection and extension logic stays in the top module.

Verification
REQ-036 Scenario 1: sel=1, immediate=12'h800, imm_sext=1, out_ready=1 -> one cycle later result=64'hFFFF_FFFF_FFFF_F800; with imm_sext=0 -> 64'h0000_0000_0000_0800.
REQ-037 Scenario 2: sel=0, register=64'h1234, then sel=2 with fwd slice0=64'hBEEF, back-to-back with out_ready=1 -> results 64'h1234 then 64'hBEEF on consecutive cycles, level never exceeds 1.
REQ-038 Scenario 3: out_ready=0 and three pushes attempted -> in_ready=0 after the second push, level=2, the third request is held; after releasing out_ready, the results drain in order.
REQ-039 Scenario 4: NUM_SRC=3, sel=3 -> result=0, err=1; err stays 1 over 5 idle cycles; err_clr for 1 cycle -> err=0; err_clr together with another bad sel -> err=1.
REQ-040 Scenario 5: level=2, then rst_n pulsed low between clock edges -> out_valid=0 and in_ready=1 immediately, and no stale result appears after release.
REQ-041 Scenario 6: level=1, then simultaneous push and pop -> level stays 1 and the new value appears on the next cycle.
